// File: rtl/mem_access_pkg.sv
// rtl/mem_access_pkg.sv - shared widths, op/width encodings and FSM states for mem_access
package mem_access_pkg;

    localparam int REG_LEN      = 32;
    localparam int REG_ADDR_LEN = 5;

    localparam logic [1:0] OP_LOAD  = 2'b01;
    localparam logic [1:0] OP_STORE = 2'b10;

    localparam logic [1:0] W_BYTE = 2'b00;
    localparam logic [1:0] W_HALF = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_DONE   = 2'b10
    } state_e;

    // Index of the final byte of an access; width 2'b11 behaves as a word.
    function automatic logic [1:0] last_byte_idx(input logic [1:0] width);
        case (width)
            W_BYTE:  return 2'd0;
            W_HALF:  return 2'd1;
            default: return 2'd3;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_if.sv
// rtl/mem_access_if.sv - byte-serial memory port between mem_access and the memory
interface mem_access_if;

    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack
    );

endinterface

// File: rtl/load_extend.sv
// rtl/load_extend.sv - sign/zero extension of an assembled load value by access width
module load_extend
    import mem_access_pkg::*;
(
    input  logic [REG_LEN-1:0] i_buf,
    input  logic [1:0]         i_width,
    input  logic               i_unsigned,
    output logic [REG_LEN-1:0] o_data
);

    logic w_sign;

    always_comb begin
        w_sign = 1'b0;
        o_data = i_buf;
        case (i_width)
            W_BYTE: begin
                w_sign = ~i_unsigned & i_buf[7];
                o_data = {{(REG_LEN-8){w_sign}}, i_buf[7:0]};
            end
            W_HALF: begin
                w_sign = ~i_unsigned & i_buf[15];
                o_data = {{(REG_LEN-16){w_sign}}, i_buf[15:0]};
            end
            default: o_data = i_buf;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// rtl/mem_access.sv - pipeline memory stage serialising loads/stores into byte accesses
module mem_access
    import mem_access_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic [REG_LEN-1:0]      i_ex_rd_data,
    input  logic [REG_ADDR_LEN-1:0] i_ex_rd_addr,
    input  logic                    i_ex_rd_enable,
    input  logic [1:0]              i_ex_mem_op,
    input  logic [1:0]              i_ex_mem_width,
    input  logic                    i_ex_mem_unsigned,
    input  logic [REG_LEN-1:0]      i_ex_store_data,
    mem_access_if.master            mem,
    output logic [REG_LEN-1:0]      o_wb_rd_data,
    output logic [REG_ADDR_LEN-1:0] o_wb_rd_addr,
    output logic                    o_wb_rd_enable,
    output logic                    o_stall_req
);

    state_e             r_state;
    logic [1:0]         r_cnt;
    logic [REG_LEN-1:0] r_buf;

    logic               w_is_load;
    logic               w_is_store;
    logic               w_mem_op;
    logic               w_last;
    logic               w_wb_en;
    logic [REG_LEN-1:0] w_ext;

    assign w_is_load  = (i_ex_mem_op == OP_LOAD);
    assign w_is_store = (i_ex_mem_op == OP_STORE);
    assign w_mem_op   = w_is_load | w_is_store;
    assign w_last     = (r_cnt == last_byte_idx(i_ex_mem_width));

    load_extend u_load_extend (
        .i_buf      (r_buf),
        .i_width    (i_ex_mem_width),
        .i_unsigned (i_ex_mem_unsigned),
        .o_data     (w_ext)
    );

    // ex_* is held stable by upstream while stalled, so op/width/address are read live.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= 2'd0;
            r_buf   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_mem_op) begin
                        r_state <= ST_ACCESS;
                        r_cnt   <= 2'd0;
                        r_buf   <= '0;
                    end
                end
                ST_ACCESS: begin
                    if (mem.mem_ack) begin
                        if (w_is_load) begin
                            r_buf[{r_cnt, 3'b000} +: 8] <= mem.mem_rdata;
                        end
                        if (w_last) begin
                            r_state <= ST_DONE;
                            r_cnt   <= 2'd0;
                        end else begin
                            r_cnt <= r_cnt + 2'd1;
                        end
                    end
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        mem.mem_req    = 1'b0;
        mem.mem_we     = 1'b0;
        mem.mem_addr   = i_ex_rd_data + {30'd0, r_cnt};
        mem.mem_wdata  = i_ex_store_data[{r_cnt, 3'b000} +: 8];
        o_stall_req    = 1'b0;
        o_wb_rd_data   = i_ex_rd_data;
        o_wb_rd_addr   = i_ex_rd_addr;
        w_wb_en        = 1'b0;
        if (rst) begin
            o_wb_rd_data = '0;
            o_wb_rd_addr = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // Zero-latency pass-through; a memory op instead stalls and bubbles wb.
                    o_stall_req = w_mem_op;
                    w_wb_en     = i_ex_rd_enable & ~w_mem_op;
                end
                ST_ACCESS: begin
                    mem.mem_req = 1'b1;
                    mem.mem_we  = w_is_store;
                    o_stall_req = 1'b1;
                end
                ST_DONE: begin
                    if (w_is_load) begin
                        o_wb_rd_data = w_ext;
                        w_wb_en      = i_ex_rd_enable;
                    end
                end
                default: w_wb_en = 1'b0;
            endcase
        end
        o_wb_rd_enable = w_wb_en & (o_wb_rd_addr != '0);
    end

endmodule

// File: tb/tb_mem_access.sv
// tb/tb_mem_access.sv - directed self-checking bench for mem_access
module tb_mem_access;
    import mem_access_pkg::*;

    logic        clk;
    logic        rst;
    logic [31:0] ex_rd_data;
    logic [4:0]  ex_rd_addr;
    logic        ex_rd_enable;
    logic [1:0]  ex_mem_op;
    logic [1:0]  ex_mem_width;
    logic        ex_mem_unsigned;
    logic [31:0] ex_store_data;
    logic [31:0] wb_rd_data;
    logic [4:0]  wb_rd_addr;
    logic        wb_rd_enable;
    logic        stall_req;

    int n_checks = 0;
    int n_bad    = 0;

    mem_access_if mif ();

    mem_access dut (
        .clk               (clk),
        .rst               (rst),
        .i_ex_rd_data      (ex_rd_data),
        .i_ex_rd_addr      (ex_rd_addr),
        .i_ex_rd_enable    (ex_rd_enable),
        .i_ex_mem_op       (ex_mem_op),
        .i_ex_mem_width    (ex_mem_width),
        .i_ex_mem_unsigned (ex_mem_unsigned),
        .i_ex_store_data   (ex_store_data),
        .mem               (mif.master),
        .o_wb_rd_data      (wb_rd_data),
        .o_wb_rd_addr      (wb_rd_addr),
        .o_wb_rd_enable    (wb_rd_enable),
        .o_stall_req       (stall_req)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Runs one load/store from the IDLE negedge through DONE; returns at the next IDLE negedge.
    task automatic do_access(input string tag, input logic [1:0] op, input logic [1:0] width,
                             input logic uns, input logic [31:0] addr, input logic [31:0] sdata,
                             input logic [4:0] rda, input logic rden, input int dly,
                             input logic [31:0] rbytes, input logic [31:0] exp_data,
                             input logic exp_en);
        int          n;
        logic [31:0] ea;
        n = (width == 2'b00) ? 1 : (width == 2'b01) ? 2 : 4;
        ex_mem_op       = op;
        ex_mem_width    = width;
        ex_mem_unsigned = uns;
        ex_rd_data      = addr;
        ex_store_data   = sdata;
        ex_rd_addr      = rda;
        ex_rd_enable    = rden;
        #1;
        check_eq({tag, "_det_stall"}, 32'(stall_req), 32'd1);
        check_eq({tag, "_det_req"}, 32'(mif.mem_req), 32'd0);
        step();
        for (int i = 0; i < n; i++) begin
            ea = addr + 32'(i);
            for (int d = 0; d < dly; d++) begin
                check_eq({tag, "_hold_req"}, 32'(mif.mem_req), 32'd1);
                check_eq({tag, "_hold_addr"}, mif.mem_addr, ea);
                step();
            end
            check_eq({tag, "_req"}, 32'(mif.mem_req), 32'd1);
            check_eq({tag, "_stall"}, 32'(stall_req), 32'd1);
            check_eq({tag, "_addr"}, mif.mem_addr, ea);
            if (op == OP_STORE) begin
                check_eq({tag, "_we"}, 32'(mif.mem_we), 32'd1);
                check_eq({tag, "_wdata"}, 32'(mif.mem_wdata), 32'(sdata[8*i +: 8]));
            end else begin
                check_eq({tag, "_we"}, 32'(mif.mem_we), 32'd0);
            end
            mif.mem_ack   = 1'b1;
            mif.mem_rdata = rbytes[8*i +: 8];
            step();
            mif.mem_ack   = 1'b0;
            mif.mem_rdata = 8'h00;
        end
        check_eq({tag, "_done_stall"}, 32'(stall_req), 32'd0);
        check_eq({tag, "_done_req"}, 32'(mif.mem_req), 32'd0);
        check_eq({tag, "_done_data"}, wb_rd_data, exp_data);
        check_eq({tag, "_done_addr"}, 32'(wb_rd_addr), 32'(rda));
        check_eq({tag, "_done_en"}, 32'(wb_rd_enable), 32'(exp_en));
        ex_mem_op = 2'b00;
        step();
    endtask

    initial begin
        rst             = 1'b1;
        ex_rd_data      = 32'hDEAD_BEEF;
        ex_rd_addr      = 5'd9;
        ex_rd_enable    = 1'b1;
        ex_mem_op       = OP_LOAD;
        ex_mem_width    = 2'b10;
        ex_mem_unsigned = 1'b0;
        ex_store_data   = 32'h0;
        mif.mem_ack     = 1'b0;
        mif.mem_rdata   = 8'h00;
        step();
        step();
        check_eq("rst_req", 32'(mif.mem_req), 32'd0);
        check_eq("rst_we", 32'(mif.mem_we), 32'd0);
        check_eq("rst_stall", 32'(stall_req), 32'd0);
        check_eq("rst_wb_en", 32'(wb_rd_enable), 32'd0);
        check_eq("rst_wb_data", wb_rd_data, 32'd0);
        check_eq("rst_wb_addr", 32'(wb_rd_addr), 32'd0);

        rst        = 1'b0;
        ex_mem_op  = 2'b00;
        ex_rd_data = 32'h0000_1234;
        ex_rd_addr = 5'd5;
        #1;
        check_eq("pass_data", wb_rd_data, 32'h0000_1234);
        check_eq("pass_addr", 32'(wb_rd_addr), 32'd5);
        check_eq("pass_en", 32'(wb_rd_enable), 32'd1);
        check_eq("pass_stall", 32'(stall_req), 32'd0);
        check_eq("pass_req", 32'(mif.mem_req), 32'd0);

        ex_mem_op   = 2'b11;
        ex_rd_data  = 32'h0BAD_F00D;
        mif.mem_ack = 1'b1;
        #1;
        check_eq("op11_stall", 32'(stall_req), 32'd0);
        check_eq("op11_data", wb_rd_data, 32'h0BAD_F00D);
        step();
        mif.mem_ack = 1'b0;
        check_eq("idle_ack_req", 32'(mif.mem_req), 32'd0);
        check_eq("idle_ack_stall", 32'(stall_req), 32'd0);
        ex_mem_op = 2'b00;

        do_access("ldw", OP_LOAD, 2'b10, 1'b0, 32'h0000_0100, 32'h0, 5'd3, 1'b1, 0,
                  32'h1234_5678, 32'h1234_5678, 1'b1);
        do_access("ldb_s", OP_LOAD, 2'b00, 1'b0, 32'h0000_0041, 32'h0, 5'd4, 1'b1, 0,
                  32'h0000_0080, 32'hFFFF_FF80, 1'b1);
        do_access("ldb_u", OP_LOAD, 2'b00, 1'b1, 32'h0000_0041, 32'h0, 5'd4, 1'b1, 1,
                  32'h0000_0080, 32'h0000_0080, 1'b1);
        do_access("ldh_s", OP_LOAD, 2'b01, 1'b0, 32'h0000_0203, 32'h0, 5'd6, 1'b1, 0,
                  32'h0000_8001, 32'hFFFF_8001, 1'b1);
        do_access("ldh_u", OP_LOAD, 2'b01, 1'b1, 32'h0000_0203, 32'h0, 5'd6, 1'b1, 0,
                  32'h0000_8001, 32'h0000_8001, 1'b1);
        do_access("sth", OP_STORE, 2'b01, 1'b0, 32'hFFFF_FFFF, 32'h0000_ABCD, 5'd8, 1'b1, 3,
                  32'h0, 32'hFFFF_FFFF, 1'b0);
        do_access("stw11", OP_STORE, 2'b11, 1'b0, 32'h0000_0010, 32'hCAFE_BABE, 5'd2, 1'b1, 0,
                  32'h0, 32'h0000_0010, 1'b0);
        do_access("ld_x0", OP_LOAD, 2'b10, 1'b0, 32'h0000_0300, 32'h0, 5'd0, 1'b1, 0,
                  32'hA5A5_5A5A, 32'hA5A5_5A5A, 1'b0);
        do_access("ld_noen", OP_LOAD, 2'b11, 1'b0, 32'h0000_0300, 32'h0, 5'd7, 1'b0, 0,
                  32'h0102_0304, 32'h0102_0304, 1'b0);

        ex_mem_op    = OP_LOAD;
        ex_mem_width = 2'b10;
        ex_rd_data   = 32'h0000_0200;
        ex_rd_addr   = 5'd7;
        ex_rd_enable = 1'b1;
        step();
        mif.mem_ack   = 1'b1;
        mif.mem_rdata = 8'hAA;
        step();
        mif.mem_rdata = 8'hBB;
        step();
        mif.mem_ack   = 1'b0;
        check_eq("abort_pre_addr", mif.mem_addr, 32'h0000_0202);
        check_eq("abort_pre_buf", dut.r_buf, 32'h0000_BBAA);
        rst = 1'b1;
        #1;
        check_eq("abort_rst_req", 32'(mif.mem_req), 32'd0);
        check_eq("abort_rst_stall", 32'(stall_req), 32'd0);
        check_eq("abort_rst_wb_en", 32'(wb_rd_enable), 32'd0);
        step();
        check_eq("abort_buf", dut.r_buf, 32'd0);
        check_eq("abort_state", 32'(dut.r_state), 32'(ST_IDLE));
        rst       = 1'b0;
        ex_mem_op = 2'b00;
        #1;
        check_eq("abort_req", 32'(mif.mem_req), 32'd0);
        check_eq("abort_stall", 32'(stall_req), 32'd0);
        check_eq("abort_wb_en", 32'(wb_rd_enable), 32'd1);
        step();

        do_access("post_rst", OP_LOAD, 2'b00, 1'b1, 32'h0000_0200, 32'h0, 5'd1, 1'b1, 0,
                  32'h0000_007F, 32'h0000_007F, 1'b1);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_access.md
MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 SHALL provide: clk  in  1  clock; all state updates on rising edge.
REQ-002 SHALL provide: rst  in  1  reset, synchronous, active-high.
REQ-003 SHALL provide: ex_rd_data  in  `RegLen  ALU result; effective address for load/store.
REQ-004 SHALL provide: ex_rd_addr  in  `RegAddrLen  destination register.
REQ-005 SHALL provide: ex_rd_enable  in  1  destination write request.
REQ-006 SHALL provide: ex_mem_op  in  2  00 none, 01 load, 10 store, 11 treated as none.
REQ-007 SHALL provide: ex_mem_width  in  2  00 byte, 01 half, 10 word, 11 treated as word.
REQ-008 SHALL provide: ex_mem_unsigned  in  1  load zero-extend when 1, sign-extend when 0.
REQ-009 SHALL provide: ex_store_data  in  `RegLen  store source value.
REQ-010 SHALL provide: mem_req / mem_we  out  1 / 1  byte-access request / write strobe.
REQ-011 SHALL provide: mem_addr  out  32  byte address; mem_wdata  out  8  write byte.
REQ-012 SHALL provide: mem_rdata  in  8  read byte; mem_ack  in  1  current byte complete (rdata valid same cycle).
REQ-013 SHALL provide: wb_rd_data  out  `RegLen, wb_rd_addr  out  `RegAddrLen, wb_rd_enable  out  1  results toward mem/wb register.
REQ-014 SHALL provide: stall_req  out  1  freeze upstream pipeline registers.

Function
REQ-015 FSM states SHALL be IDLE, ACCESS, DONE.
REQ-016 IDLE with op none: wb_* SHALL equal ex_rd_* combinationally (zero latency); stall_req=0; mem_req=0.
REQ-017 IDLE with load/store: stall_req SHALL assert combinationally the same cycle; next edge -> ACCESS, byte counter=0.
REQ-018 Byte count N SHALL be 1/2/4 per width; byte i SHALL use mem_addr = address+i (32-bit wrap, 0xFFFFFFFF+1 = 0), little-endian.
REQ-019 ACCESS: mem_req=1, stall_req=1; mem_we=1 for store with mem_wdata = store_data[8i+7:8i].
REQ-020 Request SHALL hold until mem_ack=1; ack advances counter at that edge; ack on the last byte -> DONE.
REQ-021 Load byte i SHALL be captured from mem_rdata into buffer bits [8i+7:8i] on its ack edge.
REQ-022 mem_ack while mem_req=0 SHALL be ignored.
REQ-023 DONE (one cycle): stall_req=0, mem_req=0; load drives wb_rd_data = assembled value sign/zero-extended per width; next edge -> IDLE.
REQ-024 Store SHALL force wb_rd_enable=0 in DONE; load drives ex_rd_enable.
REQ-025 wb_rd_enable SHALL be 0 whenever wb_rd_addr==0.
REQ-026 Misaligned addresses SHALL be legal (serialised bytes); no exception.
REQ-027 Upstream SHALL hold ex_* stable while stall_req=1; block SHALL re-sample op only in IDLE.

Reset
REQ-028 rst at an edge SHALL force IDLE, counter=0, buffer=0, regardless of state (aborts transaction; already-written store bytes are not undone).
REQ-029 While rst=1: mem_req=0, mem_we=0, stall_req=0, wb_rd_enable=0, wb_rd_data=0, wb_rd_addr=0.

Structure
REQ-030 `RegLen, `RegAddrLen, op/width encodings, state encodings SHALL live in config.v.
REQ-031 Sign/zero extension SHALL be a combinational sub-module load_extend (inputs: buffer, width, unsigned).

Verification
REQ-032 op none, ex_rd_data=0x1234, rd_addr=5, en=1 -> same cycle wb=0x1234/5/1, stall_req=0, mem_req=0.
REQ-033 load word, addr 0x100, memory bytes 0x78,0x56,0x34,0x12, ack each first cycle -> addrs 0x100..0x103, stall 4 cycles (+detect cycle), DONE wb_rd_data=0x12345678.
REQ-034 load byte signed, byte 0x80 -> 0xFFFFFF80; unsigned -> 0x00000080; half signed 0x8001 -> 0xFFFF8001.
REQ-035 store half 0xABCD at 0xFFFFFFFF, ack delayed 3 cycles per byte -> writes 0xCD@0xFFFFFFFF, 0xAB@0x00000000, req held through delay, wb_rd_enable=0.
REQ-036 load word, rst asserted after second ack -> next cycle IDLE, mem_req=0, stall_req=0, buffer=0.
REQ-037 load to rd_addr=0 -> full access performed, wb_rd_enable=0 in DONE.
